// File: rtl/vga_text_arbiter_pkg.sv
// Shared constants, command encodings and state type for the text-mode
// character RAM arbiter. Optional clear support: VGA_TXT_CLEAR_EN.
package vga_txt_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELLS  = 2400;
  localparam int ADDR_W = 12;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;

  typedef enum logic [1:0] {
    CMD_WRITE      = 2'b00,
    CMD_SET_CURSOR = 2'b01,
    CMD_CLEAR      = 2'b10,
    CMD_NEWLINE    = 2'b11
  } host_cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // row*80 as two shifts and an add, so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 6) + (r << 4);
  endfunction

endpackage

// File: rtl/vga_text_arbiter_if.sv
// Bus bundle between the arbiter, the display fetch path, the host command
// port and the character RAM. The arbiter takes the slave side.
interface vga_text_arbiter_if;
  import vga_txt_pkg::*;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [7:0]        disp_data;
  logic              disp_valid;

  logic              host_valid;
  logic              host_ready;
  logic [1:0]        host_cmd;
  logic [ADDR_W-1:0] host_data;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport master (
    output disp_req, disp_addr, host_valid, host_cmd, host_data, ram_rdata,
    input  disp_data, disp_valid, host_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  disp_req, disp_addr, host_valid, host_cmd, host_data, ram_rdata,
    output disp_data, disp_valid, host_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/vga_text_arbiter_cursor.sv
// Text cursor: row/col counters plus a registered linear address.
// Handles advance with wrap, newline, range-checked load and zeroing.
module vga_txt_cursor
  import vga_txt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              newline,
  input  logic              load,
  input  logic              clear,
  input  logic [ROW_W-1:0]  load_row,
  input  logic [COL_W-1:0]  load_col,
  output logic [ADDR_W-1:0] cursor_addr
);

  logic [ROW_W-1:0] row, row_next, row_inc;
  logic [COL_W-1:0] col, col_next;
  logic             in_range;

  assign in_range = (load_row < ROW_W'(ROWS)) && (load_col < COL_W'(COLS));
  assign row_inc  = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);

  // Next row/col; out-of-range loads are swallowed without moving the cursor
  always_comb begin
    row_next = row;
    col_next = col;
    if (clear) begin
      row_next = '0;
      col_next = '0;
    end else if (load) begin
      if (in_range) begin
        row_next = load_row;
        col_next = load_col;
      end
    end else if (advance) begin
      if (col == COL_W'(COLS - 1)) begin
        col_next = '0;
        row_next = row_inc;
      end else begin
        col_next = col + COL_W'(1);
      end
    end else if (newline) begin
      col_next = '0;
      row_next = row_inc;
    end
  end

  // Registers the counters and the linear address derived from their next value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row         <= '0;
      col         <= '0;
      cursor_addr <= '0;
    end else begin
      row         <= row_next;
      col         <= col_next;
      cursor_addr <= row_base(row_next) + ADDR_W'(col_next);
    end
  end

endmodule

// File: rtl/vga_text_arbiter.sv
// Character RAM arbiter: display fetches always win the single RAM port,
// host commands write through a maintained cursor. The screen-clear
// sequencer and busy flag exist only when VGA_TXT_CLEAR_EN is defined.
module vga_text_arbiter
  import vga_txt_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_text_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  state_e            state;
  host_cmd_e         cmd;
  logic              accept;
  logic              clr_write;
  logic              clr_done;
  logic [ADDR_W-1:0] clr_addr;
  logic              disp_valid_q;

  assign cmd            = host_cmd_e'(bus.host_cmd);
  assign bus.host_ready = rst_n & (state == ST_IDLE) & ~bus.disp_req;
  assign accept         = bus.host_valid & bus.host_ready;

`ifdef VGA_TXT_CLEAR_EN
  state_e            state_next;
  logic [ADDR_W-1:0] clr_addr_next;

  // State and fill-address registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  // Fill one cell per free cycle; a display fetch simply holds the address
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    clr_write     = 1'b0;
    clr_done      = 1'b0;
    if (state == ST_IDLE) begin
      if (accept && cmd == CMD_CLEAR) begin
        state_next    = ST_CLEAR;
        clr_addr_next = '0;
      end
    end else if (!bus.disp_req) begin
      clr_write = 1'b1;
      if (clr_addr == ADDR_W'(CELLS - 1)) begin
        clr_done   = 1'b1;
        state_next = ST_IDLE;
      end else begin
        clr_addr_next = clr_addr + ADDR_W'(1);
      end
    end
  end

  assign busy = (state == ST_CLEAR);
`else
  assign state     = ST_IDLE;
  assign clr_write = 1'b0;
  assign clr_done  = 1'b0;
  assign clr_addr  = '0;
  assign busy      = 1'b0;
`endif

  // RAM port mux: fetch first, then clear fill, then host write
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (rst_n) begin
      if (bus.disp_req) begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = bus.disp_addr;
      end else if (clr_write) begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = clr_addr;
        bus.ram_wdata = FILL_CHAR;
      end else if (accept && cmd == CMD_WRITE) begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = cursor_addr;
        bus.ram_wdata = bus.host_data[7:0];
      end
    end
  end

  // Fetch data arrives one cycle after the request, matching RAM latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_valid_q <= 1'b0;
    end else begin
      disp_valid_q <= bus.disp_req;
    end
  end

  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = bus.ram_rdata;

  vga_txt_cursor u_cursor (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (accept && cmd == CMD_WRITE),
    .newline     (accept && cmd == CMD_NEWLINE),
    .load        (accept && cmd == CMD_SET_CURSOR),
    .clear       (clr_done),
    .load_row    (bus.host_data[11:7]),
    .load_col    (bus.host_data[6:0]),
    .cursor_addr (cursor_addr)
  );

endmodule

// File: tb/tb_vga_text_arbiter.sv
// Directed bench for vga_text_arbiter with a behavioural 1-cycle RAM.
// Clear-sequence checks are built when VGA_TXT_CLEAR_EN is defined.
module tb_vga_text_arbiter;
  import vga_txt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cursor_addr;
  logic        busy;
  logic [7:0]  mem [0:4095];
  int          total = 0;
  int          bad = 0;
  int          cycles, stalls, writes, order_bad, ready_bad;

  vga_text_arbiter_if bus ();

  vga_text_arbiter #(.FILL_CHAR(8'h20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural character RAM with one cycle of read latency
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic hv, input logic [1:0] hc, input logic [11:0] hd,
                               input logic dr, input logic [11:0] da);
    @(negedge clk);
    bus.host_valid = hv;
    bus.host_cmd   = hc;
    bus.host_data  = hd;
    bus.disp_req   = dr;
    bus.disp_addr  = da;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    bus.ram_rdata  = 8'h00;
    rst_n          = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_cmd   = 2'b00;
    bus.host_data  = '0;
    bus.disp_req   = 1'b0;
    bus.disp_addr  = '0;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_ram_en",     32'(bus.ram_en),     32'h0);
    checkOutput("rst_ram_we",     32'(bus.ram_we),     32'h0);
    checkOutput("rst_ram_addr",   32'(bus.ram_addr),   32'h0);
    checkOutput("rst_ram_wdata",  32'(bus.ram_wdata),  32'h0);
    checkOutput("rst_disp_valid", 32'(bus.disp_valid), 32'h0);
    checkOutput("rst_host_ready", 32'(bus.host_ready), 32'h0);
    checkOutput("rst_cursor",     32'(cursor_addr),    32'h0);
    checkOutput("rst_busy",       32'(busy),           32'h0);
    rst_n = 1'b1;

    $display("[TB] host write at cursor 0");
    applyStimulus(1'b1, 2'b00, 12'h041, 1'b0, 12'd0);
    checkOutput("w0_ready", 32'(bus.host_ready), 32'h1);
    checkOutput("w0_en",    32'(bus.ram_en),     32'h1);
    checkOutput("w0_we",    32'(bus.ram_we),     32'h1);
    checkOutput("w0_addr",  32'(bus.ram_addr),   32'd0);
    checkOutput("w0_wdata", 32'(bus.ram_wdata),  32'h41);
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 12'd0);
    checkOutput("w0_cursor", 32'(cursor_addr), 32'd1);
    checkOutput("w0_idle",   32'(bus.ram_en),  32'h0);

    $display("[TB] fetch collides with host write");
    applyStimulus(1'b1, 2'b00, 12'h042, 1'b1, 12'd100);
    checkOutput("col_addr",  32'(bus.ram_addr),   32'd100);
    checkOutput("col_we",    32'(bus.ram_we),     32'h0);
    checkOutput("col_en",    32'(bus.ram_en),     32'h1);
    checkOutput("col_ready", 32'(bus.host_ready), 32'h0);
    applyStimulus(1'b1, 2'b00, 12'h042, 1'b0, 12'd0);
    checkOutput("fetch_valid", 32'(bus.disp_valid), 32'h1);
    checkOutput("fetch_data",  32'(bus.disp_data),  32'h3E);
    checkOutput("late_ready",  32'(bus.host_ready), 32'h1);
    checkOutput("late_cursor", 32'(cursor_addr),    32'd1);
    checkOutput("late_we",     32'(bus.ram_we),     32'h1);
    checkOutput("late_addr",   32'(bus.ram_addr),   32'd1);
    checkOutput("late_wdata",  32'(bus.ram_wdata),  32'h42);
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 12'd0);
    checkOutput("late_cursor2", 32'(cursor_addr),    32'd2);
    checkOutput("fetch_valid0", 32'(bus.disp_valid), 32'h0);

    $display("[TB] last cell and wrap");
    applyStimulus(1'b1, 2'b01, 12'hECF, 1'b0, 12'd0);
    checkOutput("set_noram", 32'(bus.ram_en),     32'h0);
    checkOutput("set_ready", 32'(bus.host_ready), 32'h1);
    applyStimulus(1'b1, 2'b00, 12'h05A, 1'b0, 12'd0);
    checkOutput("last_cursor", 32'(cursor_addr),   32'd2399);
    checkOutput("last_addr",   32'(bus.ram_addr),  32'd2399);
    checkOutput("last_we",     32'(bus.ram_we),    32'h1);
    checkOutput("last_wdata",  32'(bus.ram_wdata), 32'h5A);
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 12'd0);
    checkOutput("wrap_cursor", 32'(cursor_addr), 32'd0);

    $display("[TB] newline");
    applyStimulus(1'b1, 2'b01, 12'h10A, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b11, 12'h000, 1'b0, 12'd0);
    checkOutput("nl_start", 32'(cursor_addr), 32'd170);
    applyStimulus(1'b1, 2'b01, 12'hE85, 1'b0, 12'd0);
    checkOutput("nl_result", 32'(cursor_addr), 32'd240);
    applyStimulus(1'b1, 2'b11, 12'h000, 1'b0, 12'd0);
    checkOutput("nl_row29", 32'(cursor_addr), 32'd2325);
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 12'd0);
    checkOutput("nl_wrap", 32'(cursor_addr), 32'd0);

    $display("[TB] advance across end of row");
    applyStimulus(1'b1, 2'b01, 12'h04F, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b00, 12'h033, 1'b0, 12'd0);
    checkOutput("col79_cursor", 32'(cursor_addr),  32'd79);
    checkOutput("col79_addr",   32'(bus.ram_addr), 32'd79);
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 12'd0);
    checkOutput("col79_next", 32'(cursor_addr), 32'd80);

    $display("[TB] out-of-range cursor loads");
    applyStimulus(1'b1, 2'b01, 12'hF00, 1'b0, 12'd0);
    checkOutput("row30_ready", 32'(bus.host_ready), 32'h1);
    applyStimulus(1'b1, 2'b01, 12'h050, 1'b0, 12'd0);
    checkOutput("row30_cursor", 32'(cursor_addr),    32'd80);
    checkOutput("col80_ready",  32'(bus.host_ready), 32'h1);
    applyStimulus(1'b1, 2'b01, 12'hFFF, 1'b0, 12'd0);
    checkOutput("col80_cursor", 32'(cursor_addr), 32'd80);
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 12'd0);
    checkOutput("both_cursor", 32'(cursor_addr), 32'd80);

`ifdef VGA_TXT_CLEAR_EN
    $display("[TB] full clear with periodic fetches");
    applyStimulus(1'b1, 2'b10, 12'h000, 1'b0, 12'd0);
    checkOutput("clr_accept_ready", 32'(bus.host_ready), 32'h1);
    checkOutput("clr_accept_noram", 32'(bus.ram_en),     32'h0);
    cycles = 0; stalls = 0; writes = 0; order_bad = 0; ready_bad = 0;
    for (int k = 0; k < 6000; k++) begin
      applyStimulus(1'b0, 2'b00, 12'h000, (k % 8 == 7), 12'd7);
      if (busy !== 1'b1) break;
      cycles++;
      if (bus.host_ready !== 1'b0) ready_bad++;
      if (bus.disp_req) begin
        stalls++;
        if (bus.ram_we !== 1'b0) order_bad++;
      end else if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1) begin
        if (bus.ram_addr !== 12'(writes) || bus.ram_wdata !== 8'h20) order_bad++;
        writes++;
      end else begin
        order_bad++;
      end
    end
    checkOutput("clr_cycles",    32'(cycles),      32'd2742);
    checkOutput("clr_stalls",    32'(stalls),      32'd342);
    checkOutput("clr_writes",    32'(writes),      32'd2400);
    checkOutput("clr_order",     32'(order_bad),   32'd0);
    checkOutput("clr_ready_low", 32'(ready_bad),   32'd0);
    checkOutput("clr_exit_busy", 32'(busy),        32'h0);
    checkOutput("clr_exit_cur",  32'(cursor_addr), 32'd0);
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 12'd5);
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 12'd0);
    checkOutput("clr_fetch_valid", 32'(bus.disp_valid), 32'h1);
    checkOutput("clr_fetch_data",  32'(bus.disp_data),  32'h20);

    $display("[TB] reset in the middle of a clear");
    applyStimulus(1'b1, 2'b01, 12'h10A, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b10, 12'h000, 1'b0, 12'd0);
    writes = 0;
    for (int k = 0; k < 3000; k++) begin
      if (writes == 1000) break;
      applyStimulus(1'b0, 2'b00, 12'h000, (k % 8 == 7), 12'd7);
      if (!bus.disp_req && bus.ram_we === 1'b1) writes++;
    end
    checkOutput("mid_writes", 32'(writes), 32'd1000);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.disp_req = 1'b0;
    #1;
    checkOutput("mid_rst_en", 32'(bus.ram_en), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("mid_busy",   32'(busy),           32'h0);
    checkOutput("mid_cursor", 32'(cursor_addr),    32'd0);
    checkOutput("mid_ready",  32'(bus.host_ready), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 12'd0);
    checkOutput("post_busy",   32'(busy),           32'h0);
    checkOutput("post_ready",  32'(bus.host_ready), 32'h1);
    checkOutput("post_cursor", 32'(cursor_addr),    32'd0);
    checkOutput("post_idle",   32'(bus.ram_en),     32'h0);
`else
    $display("[TB] clear command without clear support");
    applyStimulus(1'b1, 2'b10, 12'h000, 1'b0, 12'd0);
    checkOutput("nclr_ready", 32'(bus.host_ready), 32'h1);
    checkOutput("nclr_noram", 32'(bus.ram_en),     32'h0);
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 12'd0);
    checkOutput("nclr_busy",   32'(busy),           32'h0);
    checkOutput("nclr_cursor", 32'(cursor_addr),    32'd80);
    checkOutput("nclr_ready2", 32'(bus.host_ready), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_text_arbiter.md
# vga_text_arbiter

Controller that owns the single-port character RAM behind `vga_char` and shares it between the display fetch path and a host command port. Display fetches always win; the host writes characters through a cursor the block maintains, and can also reposition the cursor, issue a newline or clear the screen. The block sits between the top-level glue (host/EXT_IO side) and `vga_char`, which issues fetch requests to it.

## Interface
- `FILL_CHAR`, default 8'h20: byte written by the clear sequencer.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `disp_req` in 1: display fetch request, single cycle.
- `disp_addr` in 12: cell address of the fetch, 0..2399.
- `disp_data` out 8: fetched character, equal to `ram_rdata`.
- `disp_valid` out 1: `disp_data` is valid this cycle.
- `host_valid` in 1: host command valid.
- `host_ready` out 1: block accepts the command this cycle.
- `host_cmd` in 2: 00 = write char and advance, 01 = set cursor, 10 = clear screen, 11 = newline.
- `host_data` in 12: [7:0] = char for cmd 00; {row[11:7], col[6:0]} for cmd 01.
- `ram_en`, `ram_we` out 1 each: RAM strobes.
- `ram_addr` out 12, `ram_wdata` out 8, `ram_rdata` in 8: RAM port. Read latency is 1.
- `cursor_addr` out 12: linear cursor position, 0..2399.
- `busy` out 1: clear is in progress.

## Operation
- Screen is 80 columns × 30 rows, linear address = row*80 + col. Row*80 is computed as (row<<6)+(row<<4), with no multiplier.
- The RAM port is combinational from the winning requester.
  - If `disp_req` is high: `ram_en`=1, `ram_we`=0, `ram_addr`=`disp_addr`.
  - Otherwise, a host write or clear write drives the port.
  - Otherwise, `ram_en`=0.
- `host_ready` = rst_n & state==IDLE & !disp_req.
- A command is accepted when `host_valid` and `host_ready` are both high.
- **States:** IDLE and CLEAR.
  - IDLE→CLEAR on accepted cmd 10.
  - CLEAR→IDLE after the write to address 2399.
- **cmd 00:** writes `host_data[7:0]` at `cursor_addr` in the accept cycle, then the cursor advances.
  - col 79 → col 0, row+1.
  - row 29 col 79 → address 0 (wrap; no scrolling).
- **cmd 01:** loads the cursor from row/col.
  - If row ≥ 30 or col ≥ 80, the command is accepted and the cursor is left unchanged.
- **cmd 11:** col → 0, row+1; row 29 wraps to row 0.
- **CLEAR:**
  - Writes `FILL_CHAR` to addresses 0..2399, one per cycle whenever `disp_req` is low. A cycle with `disp_req` high stalls the sequence; no address is skipped or repeated.
  - `busy`=1 for the whole of CLEAR. On exit the cursor is 0.
- **Reset (including mid-clear):** state IDLE, cursor 0. The clear is abandoned, so RAM contents are undefined.
- **Reset values:** every output is 0, with `disp_data` following `ram_rdata`.

## Timing
- Fetch: `disp_req` in cycle N → `disp_valid`=1 and `disp_data` valid in cycle N+1. `disp_valid` is `disp_req` registered.
- Host write: the RAM write happens in the accept cycle; `cursor_addr` updates at the following edge.
- `cursor_addr` is registered. A second cmd 00 in the very next cycle uses the updated cursor, so back-to-back writes run at 1 per cycle.
- Clear takes 2400 + (number of `disp_req` cycles during the clear) cycles.
- `host_ready` is 0 while `busy` is high.

## Configuration
- Macro: `VGA_TXT_CLEAR_EN`.
- **Defined:** CLEAR state, the fill sequencer and `busy` are present as described above.
- **Undefined:**
  - cmd 10 is accepted as a no-op: the cursor is unchanged and there is no RAM access.
  - `busy` is tied to 0 and the state machine has IDLE only.

## Structure
- Package `vga_txt_pkg` holds:
  - COLS=80, ROWS=30, CELLS=2400, ADDR_W=12.
  - The `host_cmd` encodings.
  - The state enum.
- Sub-module `vga_txt_cursor` holds the row/col/linear-address counters and handles advance, newline, load and range-check.
- The arbiter mux, `disp_valid` register and clear sequencer stay in the top module.

## Test plan
1. Reset, then cmd 00 with data 0x41 → RAM write at address 0 with data 0x41 in the accept cycle; `cursor_addr`=1 next cycle.
2. `disp_req` with `disp_addr`=100 and `host_valid` in the same cycle → `ram_addr`=100, `ram_we`=0, `host_ready`=0. The host write issues the next cycle. `disp_valid`=1 in N+1 with `disp_data`=`ram_rdata`.
3. cmd 01 with data 0xECF (row 29, col 79), then cmd 00 with 0x5A → write at address 2399; cursor becomes 0.
4. Cursor at address 170 (row 2, col 10), cmd 11 → cursor 240. At row 29 col 5, cmd 11 → cursor 0.
5. cmd 01 with row 30 → accepted, cursor unchanged. cmd 01 with col 80 → same result.
6. cmd 10 with `disp_req` pulsed every 8th cycle (`VGA_TXT_CLEAR_EN` defined):
   - Expect exactly 2400 writes of 0x20 at 0..2399 in order, with `busy` high throughout and the cursor 0 at exit.
   - Repeat with `rst_n` low at write 1000: state IDLE, `busy` 0, cursor 0 after the reset.
